// File: rtl/nkmm_dbus_responder_pkg.sv
// Shared constants for the nkmm data-bus responder: default widths, MMIO offsets
// and STATUS bit positions.
package nkmm_dbus_responder_pkg;

   localparam int NKMM_ACCUM_WIDTH = 24;
   localparam int NKMM_ADDR_WIDTH  = 16;

   // MMIO occupies the top MMIO_SPAN words of the address space.
   localparam int MMIO_SPAN = 16;

   localparam logic [3:0] MMIO_OFS_STATUS = 4'd0;
   localparam logic [3:0] MMIO_OFS_FIFO   = 4'd1;
   localparam logic [3:0] MMIO_OFS_GPIO   = 4'd2;
   localparam logic [3:0] MMIO_OFS_TIMER  = 4'd3;
   localparam logic [3:0] MMIO_OFS_CLR    = 4'd4;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_OVF   = 2;
   localparam int ST_BERR  = 3;
   localparam int ST_LEVEL = 4;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_NONE
   } region_e;

endpackage

// File: rtl/nkmm_sync_fifo.sv
// Synchronous FIFO with a registered head (no fall-through); a push into a full
// FIFO is accepted only when a pop happens on the same edge.
module nkmm_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   output logic                     full,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (PW+1)'(DEPTH));
   assign level   = count;
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/nkmm_dbus_responder.sv
// Data-bus target for nkmm_cpu: data RAM at the bottom of the address space and
// an MMIO block (status, output FIFO, GPIO, timer, sticky clear) at the top.
module nkmm_dbus_responder
   import nkmm_dbus_responder_pkg::*;
#(
   parameter int DATA_W     = NKMM_ACCUM_WIDTH,
   parameter int ADDR_W     = NKMM_ADDR_WIDTH,
   parameter int RAM_DEPTH  = 256,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              we_i,
   output logic [DATA_W-1:0] data_o,
   output logic [DATA_W-1:0] gpio_o,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] out_data_o,
   input  logic              out_ready_i
);

   localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_DEPTH);

   logic [DATA_W-1:0] ram [RAM_DEPTH];
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] mmio_q;
   logic              sel_ram_q;
   logic [DATA_W-1:0] timer_q;
   logic [DATA_W-1:0] gpio_q;
   logic              ovf_q;
   logic              berr_q;

   region_e           region;
   logic [3:0]        offset;
   logic [RAM_AW-1:0] ram_idx;
   logic              mmio_known;
   logic              wr_ram;
   logic              fifo_push;
   logic              gpio_wr;
   logic              timer_wr;
   logic              clr_wr;
   logic              berr_set;
   logic              ovf_set;
   logic [DATA_W-1:0] status_word;
   logic [DATA_W-1:0] mmio_rd;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [LVL_W-1:0]  fifo_level;

   assign offset  = addr_i[3:0];
   assign ram_idx = addr_i[RAM_AW-1:0];

   // Address decode and write strobes; reads are always side-effect free.
   always_comb begin
      region = REGION_NONE;
      if (addr_i < RAM_LIMIT)        region = REGION_RAM;
      else if (&addr_i[ADDR_W-1:4])  region = REGION_MMIO;

      mmio_known = (offset <= MMIO_OFS_CLR);
      wr_ram     = we_i && (region == REGION_RAM);
      fifo_push  = we_i && (region == REGION_MMIO) && (offset == MMIO_OFS_FIFO);
      gpio_wr    = we_i && (region == REGION_MMIO) && (offset == MMIO_OFS_GPIO);
      timer_wr   = we_i && (region == REGION_MMIO) && (offset == MMIO_OFS_TIMER);
      clr_wr     = we_i && (region == REGION_MMIO) && (offset == MMIO_OFS_CLR);
      berr_set   = we_i && ((region == REGION_NONE) ||
                            ((region == REGION_MMIO) && !mmio_known));
      ovf_set    = fifo_push && fifo_full && !fifo_pop;
   end

   always_comb begin
      status_word                    = '0;
      status_word[ST_FULL]           = fifo_full;
      status_word[ST_EMPTY]          = fifo_empty;
      status_word[ST_OVF]            = ovf_q;
      status_word[ST_BERR]           = berr_q;
      status_word[ST_LEVEL +: LVL_W] = fifo_level;

      mmio_rd = '0;
      case (offset)
         MMIO_OFS_STATUS: mmio_rd = status_word;
         MMIO_OFS_GPIO:   mmio_rd = gpio_q;
         MMIO_OFS_TIMER:  mmio_rd = timer_q;
         default:         mmio_rd = '0;
      endcase
   end

   // Read-first RAM: the registered read sees the word before this edge's write.
   always_ff @(posedge clk) begin
      if (!rst && wr_ram) ram[ram_idx] <= data_i;
      ram_q <= ram[ram_idx];
   end

   // Clears win over same-cycle sets on the sticky bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_ram_q <= 1'b0;
         mmio_q    <= '0;
         gpio_q    <= '0;
         timer_q   <= '0;
         ovf_q     <= 1'b0;
         berr_q    <= 1'b0;
      end else begin
         sel_ram_q <= (region == REGION_RAM);
         mmio_q    <= (region == REGION_MMIO) ? mmio_rd : '0;
         if (gpio_wr) gpio_q <= data_i;
         timer_q   <= timer_wr ? '0 : timer_q + DATA_W'(1);
         ovf_q     <= (clr_wr && data_i[ST_OVF])  ? 1'b0 : (ovf_q  | ovf_set);
         berr_q    <= (clr_wr && data_i[ST_BERR]) ? 1'b0 : (berr_q | berr_set);
      end
   end

   assign data_o      = sel_ram_q ? ram_q : mmio_q;
   assign gpio_o      = gpio_q;
   assign out_valid_o = ~fifo_empty;
   assign fifo_pop    = out_valid_o & out_ready_i;

   nkmm_sync_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (data_i),
      .full      (fifo_full),
      .pop       (fifo_pop),
      .head      (out_data_o),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

endmodule
